alu_ctrl: RTL and testbench

ALU_CTRL -- requirements
Module: alu_ctrl

---
 rtl/alu_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_alu_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl.sv
// Request/response sequencer for a multi-unit ALU: latches one operation,
// waits for the addressed unit's valid flag (bounded by TIMEOUT) and returns the result.
module alu_ctrl #(
    parameter int Width   = 16,
    parameter int TIMEOUT = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 Req_Valid,
    output logic                 Req_Ready,
    input  logic [Width-1:0]     Req_A,
    input  logic [Width-1:0]     Req_B,
    input  logic [3:0]           Req_FUN,
    output logic [Width-1:0]     ALU_A,
    output logic [Width-1:0]     ALU_B,
    output logic [3:0]           ALU_FUN,
    input  logic [2*Width-1:0]   Arith_OUT,
    input  logic [Width-1:0]     Logic_OUT,
    input  logic [Width-1:0]     Shift_OUT,
    input  logic [Width-1:0]     CMP_OUT,
    input  logic                 Arith_Flag,
    input  logic                 Logic_Flag,
    input  logic                 Shift_Flag,
    input  logic                 CMP_Flag,
    output logic                 Rsp_Valid,
    input  logic                 Rsp_Ready,
    output logic [2*Width-1:0]   Rsp_Data,
    output logic [1:0]           Rsp_Unit,
    output logic                 Rsp_Err
);

    // The timeout fires on the WAIT cycle whose count would reach TIMEOUT.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [Width-1:0]     r_alu_a;
    logic [Width-1:0]     r_alu_b;
    logic [3:0]           r_alu_fun;
    logic [7:0]           r_cnt;
    logic                 r_req_ready;
    logic                 r_rsp_valid;
    logic [2*Width-1:0]   r_rsp_data;
    logic [1:0]           r_rsp_unit;
    logic                 r_rsp_err;

    logic                 w_load_req;
    logic                 w_clr_cnt;
    logic                 w_inc_cnt;
    logic                 w_cap_ok;
    logic                 w_cap_err;
    logic                 w_sel_flag;
    logic [2*Width-1:0]   w_sel_data;

    function automatic logic [2*Width-1:0] zext(input logic [Width-1:0] v);
        return {{Width{1'b0}}, v};
    endfunction

    assign Req_Ready = r_req_ready;
    assign Rsp_Valid = r_rsp_valid;
    assign Rsp_Data  = r_rsp_data;
    assign Rsp_Unit  = r_rsp_unit;
    assign Rsp_Err   = r_rsp_err;
    assign ALU_A     = r_alu_a;
    assign ALU_B     = r_alu_b;
    assign ALU_FUN   = r_alu_fun;

    // Route the flag and result of the unit addressed by the latched opcode.
    always_comb begin
        w_sel_flag = 1'b0;
        w_sel_data = {(2*Width){1'b0}};
        case (r_alu_fun[3:2])
            2'b00: begin
                w_sel_flag = Arith_Flag;
                w_sel_data = Arith_OUT;
            end
            2'b01: begin
                w_sel_flag = Logic_Flag;
                w_sel_data = zext(Logic_OUT);
            end
            2'b10: begin
                w_sel_flag = CMP_Flag;
                w_sel_data = zext(CMP_OUT);
            end
            2'b11: begin
                w_sel_flag = Shift_Flag;
                w_sel_data = zext(Shift_OUT);
            end
            default: begin
                w_sel_flag = 1'b0;
                w_sel_data = {(2*Width){1'b0}};
            end
        endcase
    end

    // Next-state and datapath-enable decode.
    always_comb begin
        w_state_nxt = r_state;
        w_load_req  = 1'b0;
        w_clr_cnt   = 1'b0;
        w_inc_cnt   = 1'b0;
        w_cap_ok    = 1'b0;
        w_cap_err   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Req_Valid) begin
                    w_load_req  = 1'b1;
                    w_state_nxt = S_ISSUE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ISSUE: begin
                w_clr_cnt   = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // A flag on the final counted cycle still beats the timeout.
                if (w_sel_flag) begin
                    w_cap_ok    = 1'b1;
                    w_state_nxt = S_RESP;
                end else if (r_cnt >= CNT_LAST) begin
                    w_cap_err   = 1'b1;
                    w_state_nxt = S_RESP;
                end else begin
                    w_inc_cnt   = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_RESP: begin
                if (r_rsp_valid && Rsp_Ready) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_RESP;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register plus the handshake outputs registered from the next state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_req_ready <= (w_state_nxt == S_IDLE);
            r_rsp_valid <= (w_state_nxt == S_RESP);
        end
    end

    // Operand latch driving the ALU; held in every state except the accept cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_alu_a   <= {Width{1'b0}};
            r_alu_b   <= {Width{1'b0}};
            r_alu_fun <= 4'd0;
        end else if (w_load_req) begin
            r_alu_a   <= Req_A;
            r_alu_b   <= Req_B;
            r_alu_fun <= Req_FUN;
        end else begin
            r_alu_a   <= r_alu_a;
            r_alu_b   <= r_alu_b;
            r_alu_fun <= r_alu_fun;
        end
    end

    // WAIT-cycle counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt <= 8'd0;
        end else if (w_clr_cnt) begin
            r_cnt <= 8'd0;
        end else if (w_inc_cnt) begin
            r_cnt <= r_cnt + 8'd1;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Response capture; contents stay frozen until the next capture.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rsp_data <= {(2*Width){1'b0}};
            r_rsp_unit <= 2'd0;
            r_rsp_err  <= 1'b0;
        end else if (w_cap_ok) begin
            r_rsp_data <= w_sel_data;
            r_rsp_unit <= r_alu_fun[3:2];
            r_rsp_err  <= 1'b0;
        end else if (w_cap_err) begin
            r_rsp_data <= {(2*Width){1'b0}};
            r_rsp_unit <= r_alu_fun[3:2];
            r_rsp_err  <= 1'b1;
        end else begin
            r_rsp_data <= r_rsp_data;
            r_rsp_unit <= r_rsp_unit;
            r_rsp_err  <= r_rsp_err;
        end
    end

endmodule

// File: tb/tb_alu_ctrl.sv
// Randomized bench for alu_ctrl: a behavioural ALU stand-in plus a transaction-level
// reference that predicts each response from the request values and the flag schedule.
module tb_alu_ctrl;

    localparam int W  = 16;
    localparam int TO = 4;

    logic             CLK = 1'b0;
    logic             RST;
    logic             Req_Valid;
    logic             Req_Ready;
    logic [W-1:0]     Req_A;
    logic [W-1:0]     Req_B;
    logic [3:0]       Req_FUN;
    logic [W-1:0]     ALU_A;
    logic [W-1:0]     ALU_B;
    logic [3:0]       ALU_FUN;
    logic [2*W-1:0]   Arith_OUT;
    logic [W-1:0]     Logic_OUT;
    logic [W-1:0]     Shift_OUT;
    logic [W-1:0]     CMP_OUT;
    logic             Arith_Flag;
    logic             Logic_Flag;
    logic             Shift_Flag;
    logic             CMP_Flag;
    logic             Rsp_Valid;
    logic             Rsp_Ready;
    logic [2*W-1:0]   Rsp_Data;
    logic [1:0]       Rsp_Unit;
    logic             Rsp_Err;

    int n_cmp = 0;
    int n_err = 0;

    alu_ctrl #(.Width(W), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST),
        .Req_Valid(Req_Valid), .Req_Ready(Req_Ready),
        .Req_A(Req_A), .Req_B(Req_B), .Req_FUN(Req_FUN),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN),
        .Arith_OUT(Arith_OUT), .Logic_OUT(Logic_OUT),
        .Shift_OUT(Shift_OUT), .CMP_OUT(CMP_OUT),
        .Arith_Flag(Arith_Flag), .Logic_Flag(Logic_Flag),
        .Shift_Flag(Shift_Flag), .CMP_Flag(CMP_Flag),
        .Rsp_Valid(Rsp_Valid), .Rsp_Ready(Rsp_Ready),
        .Rsp_Data(Rsp_Data), .Rsp_Unit(Rsp_Unit), .Rsp_Err(Rsp_Err)
    );

    always #5 CLK = ~CLK;

    function automatic logic [2*W-1:0] arith_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic [1:0] op);
        logic signed [2*W-1:0] sa;
        logic signed [2*W-1:0] sb;
        sa = {{W{a[W-1]}}, a};
        sb = {{W{b[W-1]}}, b};
        case (op)
            2'd0:    return sa + sb;
            2'd1:    return sa - sb;
            2'd2:    return sa * sb;
            default: return -sa;
        endcase
    endfunction

    function automatic logic [W-1:0] logic_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [1:0] op);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~a;
        endcase
    endfunction

    function automatic logic [W-1:0] cmp_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [1:0] op);
        case (op)
            2'd0:    return (a == b) ? 16'd1 : 16'd0;
            2'd1:    return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
            2'd2:    return ($signed(a) > $signed(b)) ? 16'd1 : 16'd0;
            default: return (a < b) ? 16'hFFFF : 16'h0000;
        endcase
    endfunction

    function automatic logic [W-1:0] shift_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [1:0] op);
        int s;
        s = int'(b[3:0]);
        case (op)
            2'd0:    return a << s;
            2'd1:    return a >> s;
            2'd2:    return W'($signed(a) >>> s);
            default: return W'((a << s) | (a >> (W - s)));
        endcase
    endfunction

    // Expected response payload for a successful operation.
    function automatic logic [2*W-1:0] expect_data(input logic [W-1:0] a, input logic [W-1:0] b,
                                                   input logic [3:0] fun);
        logic [2*W-1:0] z;
        z = '0;
        case (fun[3:2])
            2'd0:    return arith_f(a, b, fun[1:0]);
            2'd1:    return z | logic_f(a, b, fun[1:0]);
            2'd2:    return z | cmp_f(a, b, fun[1:0]);
            default: return z | shift_f(a, b, fun[1:0]);
        endcase
    endfunction

    // ALU stand-in: every unit computes continuously from the driven operands.
    assign Arith_OUT = arith_f(ALU_A, ALU_B, ALU_FUN[1:0]);
    assign Logic_OUT = logic_f(ALU_A, ALU_B, ALU_FUN[1:0]);
    assign CMP_OUT   = cmp_f(ALU_A, ALU_B, ALU_FUN[1:0]);
    assign Shift_OUT = shift_f(ALU_A, ALU_B, ALU_FUN[1:0]);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Selected unit's flag gets sel_val; all other flags are random noise.
    task automatic set_flags(input logic [1:0] unit, input logic sel_val);
        Arith_Flag = (unit == 2'd0) ? sel_val : 1'($urandom_range(0, 1));
        Logic_Flag = (unit == 2'd1) ? sel_val : 1'($urandom_range(0, 1));
        CMP_Flag   = (unit == 2'd2) ? sel_val : 1'($urandom_range(0, 1));
        Shift_Flag = (unit == 2'd3) ? sel_val : 1'($urandom_range(0, 1));
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One request. w = WAIT cycle on which the unit flag first shows (w > TO means never),
    // bp = cycles of Rsp_Ready=0 in RESP, gap = idle cycles before the request.
    task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] fun,
                           input int w, input int bp, input int gap);
        int e;
        logic err;
        logic [2*W-1:0] xd;
        for (int g = 0; g < gap; g++) begin
            Req_Valid = 1'b0;
            tick();
            chk("idle_rsp_valid", 64'(Rsp_Valid), 64'd0);
        end
        chk("req_ready_idle", 64'(Req_Ready), 64'd1);
        Req_A = a; Req_B = b; Req_FUN = fun; Req_Valid = 1'b1;
        Rsp_Ready = (bp == 0);
        set_flags(fun[3:2], 1'b0);
        tick();
        chk("alu_a", 64'(ALU_A), 64'(a));
        chk("alu_b", 64'(ALU_B), 64'(b));
        chk("alu_fun", 64'(ALU_FUN), 64'(fun));
        chk("req_ready_busy", 64'(Req_Ready), 64'd0);
        // Extra requests while busy must be ignored.
        Req_A = W'($urandom); Req_B = W'($urandom); Req_FUN = 4'($urandom); Req_Valid = 1'b1;
        err = (w > TO);
        e   = err ? TO : w;
        xd  = err ? '0 : expect_data(a, b, fun);
        for (int j = 1; j <= e; j++) begin
            tick();
            chk("rsp_valid_early", 64'(Rsp_Valid), 64'd0);
            chk("alu_a_hold", 64'(ALU_A), 64'(a));
            set_flags(fun[3:2], (j >= w) ? 1'b1 : 1'b0);
        end
        tick();
        chk("rsp_valid", 64'(Rsp_Valid), 64'd1);
        chk("rsp_data", 64'(Rsp_Data), 64'(xd));
        chk("rsp_unit", 64'(Rsp_Unit), 64'(fun[3:2]));
        chk("rsp_err", 64'(Rsp_Err), 64'(err));
        chk("req_ready_resp", 64'(Req_Ready), 64'd0);
        for (int i = 0; i < bp; i++) begin
            set_flags(2'($urandom), 1'($urandom_range(0, 1)));
            tick();
            chk("bp_rsp_valid", 64'(Rsp_Valid), 64'd1);
            chk("bp_rsp_data", 64'(Rsp_Data), 64'(xd));
            chk("bp_rsp_err", 64'(Rsp_Err), 64'(err));
            chk("bp_rsp_unit", 64'(Rsp_Unit), 64'(fun[3:2]));
            chk("bp_req_ready", 64'(Req_Ready), 64'd0);
            chk("bp_alu_fun", 64'(ALU_FUN), 64'(fun));
        end
        Rsp_Ready = 1'b1;
        tick();
        chk("post_hs_rsp_valid", 64'(Rsp_Valid), 64'd0);
        chk("post_hs_req_ready", 64'(Req_Ready), 64'd1);
        Rsp_Ready = 1'b0;
        Req_Valid = 1'b0;
    endtask

    // Abort a request in WAIT by reset; no response may follow.
    task automatic reset_mid_wait();
        chk("rst_pre_ready", 64'(Req_Ready), 64'd1);
        Req_A = 16'h1234; Req_B = 16'h0042; Req_FUN = 4'b0001; Req_Valid = 1'b1;
        Rsp_Ready = 1'b0;
        set_flags(2'd0, 1'b0);
        tick();
        Req_Valid = 1'b0;
        tick();
        tick();
        RST = 1'b1; Req_Valid = 1'b1; Rsp_Ready = 1'b1;
        Req_A = 16'hBEEF; Req_FUN = 4'b1111;
        set_flags(2'd0, 1'b1);
        tick();
        RST = 1'b0; Req_Valid = 1'b0; Rsp_Ready = 1'b0;
        chk("rst_req_ready", 64'(Req_Ready), 64'd1);
        chk("rst_rsp_valid", 64'(Rsp_Valid), 64'd0);
        chk("rst_rsp_data", 64'(Rsp_Data), 64'd0);
        chk("rst_rsp_err", 64'(Rsp_Err), 64'd0);
        chk("rst_alu_a", 64'(ALU_A), 64'd0);
        chk("rst_alu_fun", 64'(ALU_FUN), 64'd0);
        for (int i = 0; i < TO + 3; i++) begin
            set_flags(2'($urandom), 1'b1);
            tick();
            chk("rst_no_rsp", 64'(Rsp_Valid), 64'd0);
            chk("rst_stay_idle", 64'(Req_Ready), 64'd1);
        end
    endtask

    initial begin
        RST = 1'b1; Req_Valid = 1'b0; Rsp_Ready = 1'b0;
        Req_A = '0; Req_B = '0; Req_FUN = 4'd0;
        Arith_Flag = 1'b0; Logic_Flag = 1'b0; Shift_Flag = 1'b0; CMP_Flag = 1'b0;
        tick();
        Req_Valid = 1'b1; Rsp_Ready = 1'b1; Req_A = 16'hAAAA;
        tick();
        RST = 1'b0; Req_Valid = 1'b0; Rsp_Ready = 1'b0;
        chk("reset_req_ready", 64'(Req_Ready), 64'd1);
        chk("reset_rsp_valid", 64'(Rsp_Valid), 64'd0);
        chk("reset_rsp_data", 64'(Rsp_Data), 64'd0);
        chk("reset_rsp_unit", 64'(Rsp_Unit), 64'd0);
        chk("reset_rsp_err", 64'(Rsp_Err), 64'd0);
        chk("reset_alu_a", 64'(ALU_A), 64'd0);
        chk("reset_alu_b", 64'(ALU_B), 64'd0);
        chk("reset_alu_fun", 64'(ALU_FUN), 64'd0);

        run_txn(16'h0003, 16'h0004, 4'b0000, 1, 0, 0);
        run_txn(16'hFFFE, 16'h0003, 4'b0010, 1, 0, 0);
        run_txn(16'hF0F0, 16'hFF00, 4'b0100, 1, 0, 1);
        run_txn(16'h0011, 16'h0022, 4'b1000, TO + 1, 0, 0);
        run_txn(16'h8001, 16'h0004, 4'b1110, TO, 0, 0);
        run_txn(16'h7FFF, 16'h7FFF, 4'b0010, 2, 5, 0);
        run_txn(16'h00FF, 16'h0003, 4'b1100, 1, 0, 0);
        reset_mid_wait();

        for (int t = 0; t < 200; t++) begin
            run_txn(W'($urandom), W'($urandom), 4'($urandom_range(0, 15)),
                    $urandom_range(1, TO + 2), $urandom_range(0, 3), $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
